// File: rtl/dht_pkg.sv
// Shared constants, state encoding and message-length helpers for the DHT11
// ASCII line formatter and its digit converter.
package dht_pkg;

   localparam logic [7:0] CH_T     = 8'h54;
   localparam logic [7:0] CH_H     = 8'h48;
   localparam logic [7:0] CH_COLON = 8'h3A;
   localparam logic [7:0] CH_DOT   = 8'h2E;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_E     = 8'h45;
   localparam logic [7:0] CH_R     = 8'h52;
   localparam logic [7:0] CH_P     = 8'h50;
   localparam logic [7:0] ASCII_0  = 8'h30;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   // Bytes in a normal reading line: 13 payload bytes plus the line ending.
   function automatic logic [4:0] MSG_LEN_OK(input logic eol_crlf);
      return eol_crlf ? 5'd15 : 5'd14;
   endfunction

   // Bytes in an error line: three letters plus the line ending.
   function automatic logic [4:0] MSG_LEN_ERR(input logic eol_crlf);
      return eol_crlf ? 5'd5 : 5'd4;
   endfunction

endpackage

// File: rtl/dht_bin2ascii2.sv
// Binary byte to two ASCII decimal digits; values above 99 saturate to "99".
module dht_bin2ascii2
   import dht_pkg::*;
#(
   parameter int W = 8
)
(
   input  logic [W-1:0] i_bin,
   output logic [W-1:0] o_tens,
   output logic [W-1:0] o_ones
);

   logic [W-1:0] w_clamp;

   // Saturate the input then split it into tens and ones digits as ASCII.
   always_comb begin
      w_clamp = i_bin;
      if (i_bin > W'(7'd99)) begin
         w_clamp = W'(7'd99);
      end else begin
         w_clamp = i_bin;
      end
      o_tens = W'(ASCII_0) + (w_clamp / W'(4'd10));
      o_ones = W'(ASCII_0) + (w_clamp % W'(4'd10));
   end

endmodule

// File: rtl/dht_to_uart_data.sv
// Formats one latched DHT11 reading as "T:tt.t H:hh.h" + EOL (or "ERR"/"PER"
// + EOL) and pushes it a byte per cycle into the UART TX FIFO.
// Optional build macro: DHT_PARITY_CHK_EN enables the checksum comparison
// that replaces the line with "PER" on a mismatch.
module dht_to_uart_data
   import dht_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    EOL_CRLF   = 1,
   parameter logic [DATA_WIDTH-1:0] SEP_CHAR   = 8'h20
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_trig,
   input  logic [DATA_WIDTH-1:0] temp_integral,
   input  logic [DATA_WIDTH-1:0] temp_decimal,
   input  logic [DATA_WIDTH-1:0] humi_integral,
   input  logic [DATA_WIDTH-1:0] humi_decimal,
   input  logic [DATA_WIDTH-1:0] parity,
   input  logic                  i_error,
   input  logic                  i_full,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_push,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam logic       CRLF     = (EOL_CRLF != 0);
   localparam logic [4:0] LAST_OK  = MSG_LEN_OK(CRLF) - 5'd1;
   localparam logic [4:0] LAST_ERR = MSG_LEN_ERR(CRLF) - 5'd1;

   state_t                r_state, w_state_nxt;
   logic [4:0]            r_idx;
   logic [DATA_WIDTH-1:0] r_temp_int, r_temp_dec, r_humi_int, r_humi_dec;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_t1, r_t0, r_td, r_h1, r_h0, r_hd;
   logic [DATA_WIDTH-1:0] w_t1, w_t0, w_h1, w_h0, w_td, w_hd;
   logic [DATA_WIDTH-1:0] w_byte;
   logic [4:0]            w_last_idx;
   logic                  w_push, w_par_bad, w_err_msg;

`ifdef DHT_PARITY_CHK_EN
   logic                  r_par_bad;
   logic [DATA_WIDTH-1:0] w_sum;

   assign w_sum     = temp_integral + temp_decimal + humi_integral + humi_decimal;
   assign w_par_bad = r_par_bad;

   // Capture the checksum verdict together with the sensor fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_par_bad <= 1'b0;
      end else if (r_state == IDLE && i_trig) begin
         r_par_bad <= (w_sum != parity);
      end
   end
`else
   logic w_unused_parity;

   assign w_unused_parity = ^parity;
   assign w_par_bad       = 1'b0;
`endif

   assign w_err_msg  = r_err | w_par_bad;
   assign w_last_idx = w_err_msg ? LAST_ERR : LAST_OK;

   dht_bin2ascii2 #(.W(DATA_WIDTH)) u_temp_digits (
      .i_bin  (r_temp_int),
      .o_tens (w_t1),
      .o_ones (w_t0)
   );

   dht_bin2ascii2 #(.W(DATA_WIDTH)) u_humi_digits (
      .i_bin  (r_humi_int),
      .o_tens (w_h1),
      .o_ones (w_h0)
   );

   // Fractional digits saturate at 9 and are converted to ASCII.
   always_comb begin
      w_td = DATA_WIDTH'(ASCII_0);
      w_hd = DATA_WIDTH'(ASCII_0);
      if (r_temp_dec > DATA_WIDTH'(4'd9)) begin
         w_td = DATA_WIDTH'(ASCII_0) + DATA_WIDTH'(4'd9);
      end else begin
         w_td = DATA_WIDTH'(ASCII_0) + r_temp_dec;
      end
      if (r_humi_dec > DATA_WIDTH'(4'd9)) begin
         w_hd = DATA_WIDTH'(ASCII_0) + DATA_WIDTH'(4'd9);
      end else begin
         w_hd = DATA_WIDTH'(ASCII_0) + r_humi_dec;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a push happens in SEND whenever the FIFO has room.
   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_trig) begin
               w_state_nxt = LOAD;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         LOAD: w_state_nxt = SEND;
         SEND: begin
            w_push = !i_full;
            if (w_push && (r_idx == w_last_idx)) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = SEND;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Latch the reading at the trigger so later input changes are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_temp_int <= '0;
         r_temp_dec <= '0;
         r_humi_int <= '0;
         r_humi_dec <= '0;
         r_err      <= 1'b0;
      end else if (r_state == IDLE && i_trig) begin
         r_temp_int <= temp_integral;
         r_temp_dec <= temp_decimal;
         r_humi_int <= humi_integral;
         r_humi_dec <= humi_decimal;
         r_err      <= i_error;
      end
   end

   // Register the ASCII digits in LOAD and advance the byte index on each push.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_t1  <= '0;
         r_t0  <= '0;
         r_td  <= '0;
         r_h1  <= '0;
         r_h0  <= '0;
         r_hd  <= '0;
         r_idx <= 5'd0;
      end else if (r_state == LOAD) begin
         r_t1  <= w_t1;
         r_t0  <= w_t0;
         r_td  <= w_td;
         r_h1  <= w_h1;
         r_h0  <= w_h0;
         r_hd  <= w_hd;
         r_idx <= 5'd0;
      end else if (w_push) begin
         r_idx <= r_idx + 5'd1;
      end
   end

   // Select the byte at the current index for the active message kind.
   always_comb begin
      w_byte = '0;
      if (w_err_msg) begin
         case (r_idx)
            5'd0:       w_byte = r_err ? DATA_WIDTH'(CH_E) : DATA_WIDTH'(CH_P);
            5'd1, 5'd2: w_byte = DATA_WIDTH'(CH_R);
            5'd3:       w_byte = CRLF ? DATA_WIDTH'(CH_CR) : DATA_WIDTH'(CH_LF);
            5'd4:       w_byte = DATA_WIDTH'(CH_LF);
            default:    w_byte = '0;
         endcase
      end else begin
         case (r_idx)
            5'd0:    w_byte = DATA_WIDTH'(CH_T);
            5'd1:    w_byte = DATA_WIDTH'(CH_COLON);
            5'd2:    w_byte = r_t1;
            5'd3:    w_byte = r_t0;
            5'd4:    w_byte = DATA_WIDTH'(CH_DOT);
            5'd5:    w_byte = r_td;
            5'd6:    w_byte = SEP_CHAR;
            5'd7:    w_byte = DATA_WIDTH'(CH_H);
            5'd8:    w_byte = DATA_WIDTH'(CH_COLON);
            5'd9:    w_byte = r_h1;
            5'd10:   w_byte = r_h0;
            5'd11:   w_byte = DATA_WIDTH'(CH_DOT);
            5'd12:   w_byte = r_hd;
            5'd13:   w_byte = CRLF ? DATA_WIDTH'(CH_CR) : DATA_WIDTH'(CH_LF);
            5'd14:   w_byte = DATA_WIDTH'(CH_LF);
            default: w_byte = '0;
         endcase
      end
   end

   // Output decode; data reads zero outside SEND.
   always_comb begin
      o_push = w_push;
      o_busy = (r_state != IDLE);
      o_done = (r_state == DONE);
      if (r_state == SEND) begin
         o_data = w_byte;
      end else begin
         o_data = '0;
      end
   end

endmodule

// File: tb/tb_dht_to_uart_data.sv
// Self-checking bench for dht_to_uart_data: a CRLF and an LF-only instance
// share stimulus; expected bytes are queued per message and popped on push.
module tb_dht_to_uart_data;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_trig, i_error, i_full;
   logic [7:0] temp_integral, temp_decimal, humi_integral, humi_decimal, parity;
   logic [7:0] data_c, data_l;
   logic       push_c, busy_c, done_c, push_l, busy_l, done_l;

   logic [7:0] q_c[$];
   logic [7:0] q_l[$];
   int n_vec = 0;
   int n_err = 0;
   int first_push, done_it, done_it_l;

   always #5 clk = ~clk;

   dht_to_uart_data #(.DATA_WIDTH(8), .EOL_CRLF(1), .SEP_CHAR(8'h20)) u_dut (
      .clk(clk), .rst(rst), .i_trig(i_trig),
      .temp_integral(temp_integral), .temp_decimal(temp_decimal),
      .humi_integral(humi_integral), .humi_decimal(humi_decimal),
      .parity(parity), .i_error(i_error), .i_full(i_full),
      .o_data(data_c), .o_push(push_c), .o_busy(busy_c), .o_done(done_c)
   );

   dht_to_uart_data #(.DATA_WIDTH(8), .EOL_CRLF(0), .SEP_CHAR(8'h20)) u_dut_lf (
      .clk(clk), .rst(rst), .i_trig(i_trig),
      .temp_integral(temp_integral), .temp_decimal(temp_decimal),
      .humi_integral(humi_integral), .humi_decimal(humi_decimal),
      .parity(parity), .i_error(i_error), .i_full(i_full),
      .o_data(data_l), .o_push(push_l), .o_busy(busy_l), .o_done(done_l)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input int ti, input int td, input int hi, input int hd,
                         input bit err, input bit good_par);
      temp_integral = 8'(ti);
      temp_decimal  = 8'(td);
      humi_integral = 8'(hi);
      humi_decimal  = 8'(hd);
      i_error       = err;
      parity        = 8'(ti + td + hi + hd);
      if (!good_par) parity = parity + 8'd1;
   endtask

   // Reference model: queue the expected line for both instances.
   task automatic exp_line();
      logic [7:0] b[$];
      int ti, td, hi, hd;
      bit perr;
      ti = (temp_integral > 8'd99) ? 99 : int'(temp_integral);
      hi = (humi_integral > 8'd99) ? 99 : int'(humi_integral);
      td = (temp_decimal  > 8'd9)  ? 9  : int'(temp_decimal);
      hd = (humi_decimal  > 8'd9)  ? 9  : int'(humi_decimal);
      perr = 1'b0;
`ifdef DHT_PARITY_CHK_EN
      perr = (8'(temp_integral + temp_decimal + humi_integral + humi_decimal) != parity);
`endif
      if (i_error) b = '{8'h45, 8'h52, 8'h52};
      else if (perr) b = '{8'h50, 8'h52, 8'h52};
      else b = '{8'h54, 8'h3A, 8'(48 + ti / 10), 8'(48 + ti % 10), 8'h2E, 8'(48 + td),
                 8'h20, 8'h48, 8'h3A, 8'(48 + hi / 10), 8'(48 + hi % 10), 8'h2E, 8'(48 + hd)};
      foreach (b[i]) begin
         q_c.push_back(b[i]);
         q_l.push_back(b[i]);
      end
      q_c.push_back(8'h0D);
      q_c.push_back(8'h0A);
      q_l.push_back(8'h0A);
   endtask

   // Trigger one message and follow it, optionally stalling, re-triggering or resetting.
   task automatic run_msg(input int full_at, input int full_len, input int retrig_at,
                          input int rst_at);
      int pushes = 0;
      int full_cnt = 0;
      bit did_retrig = 1'b0;
      logic [7:0] e;
      first_push = -1;
      done_it = -1;
      done_it_l = -1;
      exp_line();
      @(posedge clk); #1;
      i_trig = 1'b1;
      for (int it = 0; it < 200; it++) begin
         @(posedge clk); #1;
         i_trig = 1'b0;
         i_full = 1'b0;
         rst = 1'b0;
         if (pushes == full_at && full_cnt < full_len) begin
            i_full = 1'b1;
            full_cnt++;
         end
         if (pushes == retrig_at && !did_retrig) begin
            did_retrig = 1'b1;
            i_trig = 1'b1;
            set_in(11, 1, 22, 2, 1'b1, 1'b0);
         end
         if (pushes == rst_at) rst = 1'b1;
         @(negedge clk);
         if (it == 0) begin
            chk("load_busy", 32'(busy_c), 32'd1);
            chk("load_nopush", 32'(push_c), 32'd0);
         end
         if (push_c) begin
            if (first_push < 0) first_push = it;
            pushes++;
            e = (q_c.size() > 0) ? q_c.pop_front() : 8'hFF;
            chk("byte_crlf", 32'(data_c), 32'(e));
         end else if (i_full && q_c.size() > 0) begin
            chk("held_data", 32'(data_c), 32'(q_c[0]));
         end
         if (push_l) begin
            e = (q_l.size() > 0) ? q_l.pop_front() : 8'hFF;
            chk("byte_lf", 32'(data_l), 32'(e));
         end
         if (done_l) done_it_l = it;
         if (done_c) done_it = it;
         if (rst) begin
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("rst_push", 32'(push_c), 32'd0);
            chk("rst_busy", 32'(busy_c), 32'd0);
            chk("rst_busy_lf", 32'(busy_l), 32'd0);
            q_c.delete();
            q_l.delete();
            return;
         end
         if (done_it >= 0) break;
      end
      chk("done_seen", 32'(done_it >= 0), 32'd1);
      chk("queue_empty", 32'(q_c.size()), 32'd0);
      chk("queue_empty_lf", 32'(q_l.size()), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("busy_drop", 32'(busy_c), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      i_trig = 1'b0;
      i_full = 1'b0;
      set_in(0, 0, 0, 0, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_push", 32'(push_c), 32'd0);
      chk("reset_busy", 32'(busy_c), 32'd0);
      chk("reset_done", 32'(done_c), 32'd0);
      chk("reset_data", 32'(data_c), 32'd0);
      rst = 1'b0;

      // Nominal reading 25.3 / 60.0.
      set_in(25, 3, 60, 0, 1'b0, 1'b1);
      run_msg(-1, 0, -1, -1);
      chk("first_push_lat", 32'(first_push), 32'd1);
      chk("done_lat", 32'(done_it), 32'd16);
      chk("done_lat_lf", 32'(done_it_l), 32'd15);

      // Saturation of both integer and fractional fields.
      set_in(123, 0, 7, 12, 1'b0, 1'b1);
      run_msg(-1, 0, -1, -1);
      chk("clamp_done", 32'(done_it), 32'd16);

      // Sensor error wins over a bad checksum.
      set_in(25, 3, 60, 0, 1'b1, 1'b0);
      run_msg(-1, 0, -1, -1);
      chk("err_done", 32'(done_it), 32'd6);
      chk("err_done_lf", 32'(done_it_l), 32'd5);

      // FIFO full for 4 cycles at byte 5.
      set_in(31, 7, 45, 5, 1'b0, 1'b1);
      run_msg(5, 4, -1, -1);
      chk("full_done", 32'(done_it), 32'd20);
      chk("full_done_lf", 32'(done_it_l), 32'd19);

      // Re-trigger and input change mid-message are ignored.
      set_in(18, 4, 52, 9, 1'b0, 1'b1);
      run_msg(-1, 0, 3, -1);
      chk("retrig_done", 32'(done_it), 32'd16);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_second_msg", 32'(push_c | busy_c), 32'd0);
      end

      // Reset mid-message, then a complete fresh line.
      set_in(42, 1, 33, 8, 1'b0, 1'b1);
      run_msg(-1, 0, -1, 8);
      set_in(25, 3, 60, 0, 1'b0, 1'b1);
      run_msg(-1, 0, -1, -1);
      chk("after_rst_done", 32'(done_it), 32'd16);

      // Checksum byte 0 vs correct 88 on the 25.3 / 60.0 reading.
      set_in(25, 3, 60, 0, 1'b0, 1'b1);
      parity = 8'd0;
      run_msg(-1, 0, -1, -1);
`ifdef DHT_PARITY_CHK_EN
      chk("par_bad_done", 32'(done_it), 32'd6);
`else
      chk("par_bad_done", 32'(done_it), 32'd16);
`endif
      parity = 8'd88;
      run_msg(-1, 0, -1, -1);
      chk("par_ok_done", 32'(done_it), 32'd16);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
